// File: rtl/coded_res_decoder.sv
// Frame decoder: buffers 8 two-lane words, checks weighted-sum checksum, replays words with status.
// Optional CODED_ERR_CNT_EN adds a saturating err_cnt output counting failed frames.
module coded_res_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        chk_valid,
    output logic        chk_ready,
    input  logic [47:0] chk_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [2:0]  out_idx,
    output logic        out_last,
    output logic        out_err,
    output logic        frame_err
`ifdef CODED_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    typedef enum logic [1:0] {StRecv, StWaitChk, StCmp, StSend} state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [21:0] acc1_q, acc1_d, acc2_q, acc2_d;
    logic [47:0] chk_q, chk_d;
    logic        err_q, err_d;
    logic [31:0] buf_q [8];
    logic        buf_we;
    logic        cmp_err;

    // Lane value sign-extended to 22 bits times unsigned weight idx+1; result wraps mod 2^22.
    function automatic logic [21:0] wprod(input logic [15:0] a, input logic [2:0] idx);
        logic [21:0] a_ext;
        logic [3:0]  w;
        a_ext = {{6{a[15]}}, a};
        w     = {1'b0, idx} + 4'd1;
        return a_ext * {18'd0, w};
    endfunction

    assign cmp_err = (chk_q[21:0] != acc1_q) | (chk_q[45:24] != acc2_q)
                   | (|chk_q[23:22]) | (|chk_q[47:46]);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc1_d    = acc1_q;
        acc2_d    = acc2_q;
        chk_d     = chk_q;
        err_d     = err_q;
        buf_we    = 1'b0;
        in_ready  = 1'b0;
        chk_ready = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            StRecv: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_we = 1'b1;
                    acc1_d = acc1_q + wprod(in_data[15:0], idx_q);
                    acc2_d = acc2_q + wprod(in_data[31:16], idx_q);
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StWaitChk;
                end
            end
            StWaitChk: begin
                chk_ready = 1'b1;
                if (chk_valid) begin
                    chk_d   = chk_data;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                err_d     = cmp_err;
                frame_err = cmp_err;
                state_d   = StSend;
            end
            StSend: begin
                out_valid = 1'b1;
                out_data  = buf_q[idx_q];
                out_idx   = idx_q;
                out_last  = (idx_q == 3'd7);
                out_err   = err_q;
                if (out_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        acc1_d  = '0;
                        acc2_d  = '0;
                        state_d = StRecv;
                    end
                end
            end
            default: state_d = StRecv;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRecv;
            idx_q   <= '0;
            acc1_q  <= '0;
            acc2_q  <= '0;
            chk_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 8; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            if (buf_we) buf_q[idx_q] <= in_data;
        end
    end

`ifdef CODED_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (frame_err && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
